// File: rtl/mux_scan_serializer.sv
// mux_scan_serializer: drives an external bit-select mux and streams the
// selected bits LSB first. Define SCAN_PARITY_EN for a trailing parity bit.
module mux_scan_serializer #(
   parameter int WIDTH = 8,
   parameter int SEL_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_valid,
   input  logic [WIDTH-1:0] load_data,
   output logic             load_ready,
   output logic [WIDTH-1:0] mux_in,
   output logic [SEL_W-1:0] mux_sel,
   input  logic             mux_out,
   output logic             bit_valid,
   output logic             bit_data,
   output logic             bit_last,
   input  logic             bit_ready,
   output logic             busy
);

`ifdef SCAN_PARITY_EN
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_PAR   = 2'd2
   } state_t;
`else
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1
   } state_t;
`endif

   localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(WIDTH - 1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_mux_in;
   logic [SEL_W-1:0] r_mux_sel;

   logic w_sel_last;
   logic w_load_ready;
   logic w_bit_valid;
   logic w_bit_data;
   logic w_bit_last;
   logic w_busy;
   logic w_load_fire;
   logic w_bit_fire;

`ifdef SCAN_PARITY_EN
   logic w_parity;
   assign w_parity = ^r_mux_in;
`endif

   assign w_sel_last  = (r_mux_sel == SEL_LAST);
   assign w_load_fire = load_valid & w_load_ready;
   assign w_bit_fire  = w_bit_valid & bit_ready;

   // State register; reset overrides any handshake in the same cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state: load starts a frame, accepted last bit ends it
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (w_load_fire) begin
               w_state_nxt = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (w_bit_fire && w_sel_last) begin
`ifdef SCAN_PARITY_EN
               w_state_nxt = S_PAR;
`else
               w_state_nxt = S_IDLE;
`endif
            end
         end
`ifdef SCAN_PARITY_EN
         S_PAR: begin
            if (w_bit_fire) begin
               w_state_nxt = S_IDLE;
            end
         end
`endif
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Outputs decoded from state; data bit is the mux feedback unregistered
   always_comb begin
      w_load_ready = 1'b0;
      w_bit_valid  = 1'b0;
      w_bit_data   = 1'b0;
      w_bit_last   = 1'b0;
      w_busy       = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            w_load_ready = ~rst;
         end
         S_SHIFT: begin
            w_bit_valid = 1'b1;
            w_bit_data  = mux_out;
            w_busy      = 1'b1;
`ifdef SCAN_PARITY_EN
            w_bit_last  = 1'b0;
`else
            w_bit_last  = w_sel_last;
`endif
         end
`ifdef SCAN_PARITY_EN
         S_PAR: begin
            w_bit_valid = 1'b1;
            w_bit_data  = w_parity;
            w_bit_last  = 1'b1;
            w_busy      = 1'b1;
         end
`endif
         default: begin
            w_load_ready = 1'b0;
         end
      endcase
   end

   // Mux drive: word captured on load, select walks one step per transfer
   always_ff @(posedge clk) begin
      if (rst) begin
         r_mux_in  <= '0;
         r_mux_sel <= '0;
      end else if (w_load_fire) begin
         r_mux_in  <= load_data;
         r_mux_sel <= '0;
      end else if (r_state == S_SHIFT && w_bit_fire) begin
         if (w_sel_last) begin
            r_mux_sel <= '0;
         end else begin
            r_mux_sel <= r_mux_sel + SEL_W'(1);
         end
      end
   end

   assign load_ready = w_load_ready;
   assign mux_in     = r_mux_in;
   assign mux_sel    = r_mux_sel;
   assign bit_valid  = w_bit_valid;
   assign bit_data   = w_bit_data;
   assign bit_last   = w_bit_last;
   assign busy       = w_busy;

endmodule

// File: tb/tb_mux_scan_serializer.sv
// tb_mux_scan_serializer: directed bench with an ideal 8:1 mux model.
// Parity-frame checks are enabled when SCAN_PARITY_EN is defined.
module tb_mux_scan_serializer;

`ifdef SCAN_PARITY_EN
   localparam int NB = 9;
`else
   localparam int NB = 8;
`endif

   logic       clk;
   logic       rst;
   logic       load_valid;
   logic [7:0] load_data;
   logic       load_ready;
   logic [7:0] mux_in;
   logic [2:0] mux_sel;
   logic       mux_out;
   logic       bit_valid;
   logic       bit_data;
   logic       bit_last;
   logic       bit_ready;
   logic       busy;

   int n_checks = 0;
   int n_fail   = 0;

   mux_scan_serializer #(.WIDTH(8), .SEL_W(3)) dut (
      .clk        (clk),
      .rst        (rst),
      .load_valid (load_valid),
      .load_data  (load_data),
      .load_ready (load_ready),
      .mux_in     (mux_in),
      .mux_sel    (mux_sel),
      .mux_out    (mux_out),
      .bit_valid  (bit_valid),
      .bit_data   (bit_data),
      .bit_last   (bit_last),
      .bit_ready  (bit_ready),
      .busy       (busy)
   );

   // ideal mux8to1
   assign mux_out = mux_in[mux_sel];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic exp_bit(logic [7:0] w, int i);
      if (i < 8) return w[i];
      return ^w;
   endfunction

   task automatic test_reset();
      repeat (2) @(negedge clk);
      n_checks++;
      if (load_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_load_ready: got %b want 0", load_ready);
      end
      n_checks++;
      if (bit_valid !== 1'b0 || bit_last !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_flags: got v%b l%b b%b want 000",
                  bit_valid, bit_last, busy);
      end
      n_checks++;
      if (mux_sel !== 3'd0 || mux_in !== 8'h00) begin
         n_fail++;
         $display("FAIL rst_mux: got sel %0d in %h want 0 00",
                  mux_sel, mux_in);
      end
      rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if (load_ready !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_ready: got r%b b%b want 1 0", load_ready, busy);
      end
   endtask

   task automatic test_basic(input logic [7:0] w);
      @(negedge clk);
      load_data = w; load_valid = 1'b1; bit_ready = 1'b1;
      @(negedge clk);
      load_valid = 1'b0;
      for (int i = 0; i < NB; i++) begin
         n_checks++;
         if (bit_valid !== 1'b1 || busy !== 1'b1 || load_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_valid[%0d]: got v%b b%b r%b want 110",
                     i, bit_valid, busy, load_ready);
         end
         if (i < 8) begin
            n_checks++;
            if (mux_sel !== 3'(i)) begin
               n_fail++;
               $display("FAIL basic_sel[%0d]: got %0d want %0d",
                        i, mux_sel, i);
            end
         end
         n_checks++;
         if (bit_data !== exp_bit(w, i)) begin
            n_fail++;
            $display("FAIL basic_data[%0d]: got %b want %b",
                     i, bit_data, exp_bit(w, i));
         end
         n_checks++;
         if (bit_last !== (i == NB - 1)) begin
            n_fail++;
            $display("FAIL basic_last[%0d]: got %b want %b",
                     i, bit_last, (i == NB - 1));
         end
         @(negedge clk);
      end
      n_checks++;
      if (bit_valid !== 1'b0 || load_ready !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_end: got v%b r%b b%b want 010",
                  bit_valid, load_ready, busy);
      end
   endtask

   task automatic test_backpressure();
      @(negedge clk);
      load_data = 8'b10101100; load_valid = 1'b1; bit_ready = 1'b1;
      @(negedge clk);
      load_valid = 1'b0;
      for (int i = 0; i < NB; i++) begin
         n_checks++;
         if (bit_data !== exp_bit(8'b10101100, i)
             || bit_last !== (i == NB - 1) || bit_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_bit[%0d]: got d%b l%b v%b want d%b l%b v1",
                     i, bit_data, bit_last, bit_valid,
                     exp_bit(8'b10101100, i), (i == NB - 1));
         end
         if (i == 2) begin
            bit_ready = 1'b0;
            for (int k = 0; k < 3; k++) begin
               @(negedge clk);
               n_checks++;
               if (mux_sel !== 3'd2 || bit_data !== 1'b1
                   || bit_valid !== 1'b1 || bit_last !== 1'b0) begin
                  n_fail++;
                  $display("FAIL bp_hold[%0d]: got sel%0d d%b v%b l%b want 2 1 1 0",
                           k, mux_sel, bit_data, bit_valid, bit_last);
               end
            end
            bit_ready = 1'b1;
         end
         @(negedge clk);
      end
      n_checks++;
      if (bit_valid !== 1'b0 || load_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_end: got v%b r%b want 0 1", bit_valid, load_ready);
      end
   endtask

   task automatic test_ignore_load();
      @(negedge clk);
      load_data = 8'hA5; load_valid = 1'b1; bit_ready = 1'b1;
      @(negedge clk);
      load_valid = 1'b0;
      for (int i = 0; i < NB; i++) begin
         n_checks++;
         if (bit_data !== exp_bit(8'hA5, i) || mux_in !== 8'hA5) begin
            n_fail++;
            $display("FAIL ign_bit[%0d]: got d%b in %h want d%b in a5",
                     i, bit_data, mux_in, exp_bit(8'hA5, i));
         end
         if (i == 4) begin
            load_data = 8'hFF; load_valid = 1'b1;
            n_checks++;
            if (load_ready !== 1'b0) begin
               n_fail++;
               $display("FAIL ign_ready: got %b want 0", load_ready);
            end
         end else begin
            load_valid = 1'b0;
         end
         @(negedge clk);
      end
      load_valid = 1'b0;
      n_checks++;
      if (mux_in !== 8'hA5 || bit_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL ign_end: got in %h v%b want a5 0", mux_in, bit_valid);
      end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      load_data = 8'h3C; load_valid = 1'b1; bit_ready = 1'b1;
      @(negedge clk);
      load_valid = 1'b0;
      for (int i = 0; i < 6; i++) begin
         n_checks++;
         if (mux_sel !== 3'(i) || bit_last !== 1'b0) begin
            n_fail++;
            $display("FAIL rm_pre[%0d]: got sel%0d l%b want %0d 0",
                     i, mux_sel, bit_last, i);
         end
         if (i == 5) rst = 1'b1;
         @(negedge clk);
      end
      n_checks++;
      if (bit_valid !== 1'b0 || busy !== 1'b0 || bit_last !== 1'b0) begin
         n_fail++;
         $display("FAIL rm_flags: got v%b b%b l%b want 000",
                  bit_valid, busy, bit_last);
      end
      n_checks++;
      if (mux_sel !== 3'd0 || mux_in !== 8'h00 || load_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL rm_mux: got sel%0d in %h r%b want 0 00 0",
                  mux_sel, mux_in, load_ready);
      end
      rst = 1'b0;
      @(negedge clk);
      load_data = 8'h01; load_valid = 1'b1;
      @(negedge clk);
      load_valid = 1'b0;
      for (int i = 0; i < NB; i++) begin
         n_checks++;
         if (bit_data !== exp_bit(8'h01, i) || bit_last !== (i == NB - 1)
             || bit_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rm_bit[%0d]: got d%b l%b v%b want d%b l%b v1",
                     i, bit_data, bit_last, bit_valid,
                     exp_bit(8'h01, i), (i == NB - 1));
         end
         @(negedge clk);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] w;
      int         idx;
      @(negedge clk);
      load_data = 8'hF0; load_valid = 1'b1; bit_ready = 1'b1;
      for (int c = 0; c <= 2 * NB; c++) begin
         @(negedge clk);
         if (c == 0) load_data = 8'h0F;
         if (c == NB + 1) load_valid = 1'b0;
         if (c == NB) begin
            n_checks++;
            if (bit_valid !== 1'b0 || load_ready !== 1'b1) begin
               n_fail++;
               $display("FAIL b2b_gap: got v%b r%b want 0 1",
                        bit_valid, load_ready);
            end
         end else begin
            w   = (c < NB) ? 8'hF0 : 8'h0F;
            idx = (c < NB) ? c : c - NB - 1;
            n_checks++;
            if (bit_valid !== 1'b1 || bit_data !== exp_bit(w, idx)
                || bit_last !== (idx == NB - 1)) begin
               n_fail++;
               $display("FAIL b2b_bit[%0d]: got v%b d%b l%b want v1 d%b l%b",
                        c, bit_valid, bit_data, bit_last,
                        exp_bit(w, idx), (idx == NB - 1));
            end
         end
      end
      @(negedge clk);
      n_checks++;
      if (bit_valid !== 1'b0 || load_ready !== 1'b1 || mux_in !== 8'h0F) begin
         n_fail++;
         $display("FAIL b2b_end: got v%b r%b in %h want 0 1 0f",
                  bit_valid, load_ready, mux_in);
      end
   endtask

`ifdef SCAN_PARITY_EN
   task automatic test_parity(input logic [7:0] w, input logic p);
      @(negedge clk);
      load_data = w; load_valid = 1'b1; bit_ready = 1'b1;
      @(negedge clk);
      load_valid = 1'b0;
      repeat (8) @(negedge clk);
      n_checks++;
      if (bit_valid !== 1'b1 || bit_data !== p || bit_last !== 1'b1) begin
         n_fail++;
         $display("FAIL parity_%h: got v%b d%b l%b want v1 d%b l1",
                  w, bit_valid, bit_data, bit_last, p);
      end
      @(negedge clk);
      n_checks++;
      if (bit_valid !== 1'b0 || load_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL parity_end_%h: got v%b r%b want 0 1",
                  w, bit_valid, load_ready);
      end
   endtask
`endif

   initial begin
      rst        = 1'b1;
      load_valid = 1'b0;
      load_data  = 8'h00;
      bit_ready  = 1'b0;
      test_reset();
      test_basic(8'b10101100);
      test_basic(8'h5A);
      test_backpressure();
      test_ignore_load();
      test_reset_mid();
      test_back_to_back();
`ifdef SCAN_PARITY_EN
      test_parity(8'b10101100, 1'b0);
      test_parity(8'b00000111, 1'b1);
`endif
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mux_scan_serializer.md
Name: mux_scan_serializer

Overview:
- Upstream controller for the 8:1 bit-select mux (`mux8to1`).
- Accepts a parallel word over a valid/ready handshake, holds it on the mux data inputs, and steps the mux select from 0 to WIDTH-1.
- Returns each selected bit, read back from the mux output, as a serial stream with valid/ready/last.
- Turns the combinational mux into a flow-controlled parallel-to-serial stage, LSB first.

Parameters:
- WIDTH, 8, word width; equals the number of mux inputs; power of two, 2 to 256.
- SEL_W, 3, select width; must equal $clog2(WIDTH).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- load_valid  input  1  parallel word offered
- load_data  input  WIDTH  word to serialize
- load_ready  output  1  block can accept a word
- mux_in  output  WIDTH  drives mux data inputs (registered)
- mux_sel  output  SEL_W  drives mux select (registered)
- mux_out  input  1  mux output fed back (combinational path from mux_sel/mux_in)
- bit_valid  output  1  serial bit available
- bit_data  output  1  serial bit
- bit_last  output  1  final bit of the frame
- bit_ready  input  1  downstream accepts bit
- busy  output  1  frame in progress

Behaviour:
- One clock domain. Synchronous active-high reset. All state updates on the rising edge of clk.
- Reset values: state=IDLE, mux_in=0, mux_sel=0, bit_valid=0, bit_last=0, busy=0.
- load_ready = (state==IDLE) & ~rst, so it is 0 while rst is high.
- States:
  - IDLE: load_ready=1, bit_valid=0.
  - SHIFT: bit_valid=1, busy=1.
  - PAR: only with the optional feature; bit_valid=1, busy=1.
- IDLE -> SHIFT on load_valid & load_ready. Same edge: mux_in<=load_data, mux_sel<=0.
- In SHIFT, bit_data = mux_out, a combinational pass-through with zero added latency. It equals mux_in[mux_sel].
- bit_last=1 in SHIFT when mux_sel==WIDTH-1 (or in PAR when the feature is enabled).
- Transfer occurs on a cycle where bit_valid & bit_ready.
  - Not last: mux_sel<=mux_sel+1.
  - Last: state<=IDLE, mux_sel<=0. With the feature, the last data bit goes to PAR instead.
- Backpressure: while bit_ready=0, mux_sel, mux_in, bit_valid and bit_last hold. bit_data stays stable.
- mux_sel never wraps inside a frame. The increment past WIDTH-1 is never taken.
- Latency: first bit_valid appears the cycle after the load handshake.
  - A frame occupies WIDTH cycles under continuous ready.
  - One IDLE cycle separates back-to-back frames, giving a minimum frame period of WIDTH+1 cycles.
- load_valid during SHIFT/PAR is ignored: load_ready=0 and mux_in is unchanged.
- mux_in is unchanged from load until the next accepted load.
- Reset mid-frame: next cycle state=IDLE, bit_valid=0. The partial frame is discarded with no bit_last.
- rst takes priority over all simultaneous handshakes.

Optional Feature:
- Macro SCAN_PARITY_EN.
- Defined: after the last data bit the block enters PAR and emits one extra bit.
  - The extra bit is even parity, ^mux_in, with bit_last=1.
  - Data bit WIDTH-1 then has bit_last=0.
  - Transfer in PAR -> IDLE.
  - Frame is WIDTH+1 bits.
- Undefined: no PAR state, and the frame is WIDTH bits.

Test Plan:
- Load 8'b10101100, bit_ready=1 held, mux modelled ideally -> mux_sel 0..7 on consecutive cycles; bit_data 0,0,1,1,0,1,0,1; bit_last only on the 8th bit; load_ready returns 1 the cycle after.
- Same word, bit_ready low for 3 cycles at mux_sel=2 -> mux_sel holds at 2 and bit_data=1 throughout; the stream then resumes with no bit lost or duplicated.
- Load 8'hA5, then pulse load_valid with 8'hFF at mux_sel=4 -> load_ready=0; mux_in stays 8'hA5; all 8 bits follow 8'hA5.
- Assert rst for 1 cycle at mux_sel=5 -> next cycle bit_valid=0, busy=0, mux_sel=0, mux_in=0; no bit_last; a fresh load of 8'h01 then serializes correctly.
- Two words 8'hF0 and 8'h0F offered back-to-back, continuous ready -> 17-cycle span: 8 bits, 1 idle cycle, 8 bits.
- SCAN_PARITY_EN defined:
  - 8'b10101100 -> 9 bits, 9th=0 with bit_last.
  - 8'b00000111 -> 9th=1.
